// File: rtl/register_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero; a synchronous reset clears every entry.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reg1,
    input  logic [ADDR_WIDTH-1:0] reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic                  regwrite,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    // Entry 0 has no storage: it is produced by the read mux instead.
    logic [DATA_WIDTH-1:0] mem_q [1:NREGS-1];
    logic [DATA_WIDTH-1:0] mem_d [1:NREGS-1];

    always_comb begin
        mem_d = mem_q;
        if (regwrite && (write_reg != '0)) begin
            mem_d[write_reg] = writedata;
        end
    end

    // Reset wins over a write issued on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // No write bypass: a pending write becomes visible only after its edge.
    assign data1 = (reg1 == '0) ? '0 : mem_q[reg1];
    assign data2 = (reg2 == '0) ? '0 : mem_q[reg2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    logic                  clk;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] reg1;
    logic [ADDR_WIDTH-1:0] reg2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic                  regwrite;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;

    int n_checks;
    int n_fails;

    register_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .reg1     (reg1),
        .reg2     (reg2),
        .write_reg(write_reg),
        .regwrite (regwrite),
        .writedata(writedata),
        .data1    (data1),
        .data2    (data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] got,
                         input logic [DATA_WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Performs one write on the next edge, then drops the enable.
    task automatic write(input logic [ADDR_WIDTH-1:0] idx, input logic [DATA_WIDTH-1:0] val);
        write_reg = idx;
        writedata = val;
        regwrite  = 1'b1;
        @(posedge clk);
        #1;
        regwrite  = 1'b0;
    endtask

    task automatic read(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
        reg1 = a;
        reg2 = b;
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b0;
        reg1      = '0;
        reg2      = '0;
        write_reg = '0;
        regwrite  = 1'b0;
        writedata = '0;

        // Register 0 reads zero even before any reset.
        read(0, 0);
        check("r0_prereset_d1", data1, 32'h0);
        check("r0_prereset_d2", data2, 32'h0);

        // Reset, then sweep every index on both ports.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read(ADDR_WIDTH'(i), ADDR_WIDTH'(31 - i));
            check($sformatf("reset_d1_r%0d", i), data1, 32'h0);
            check($sformatf("reset_d2_r%0d", 31 - i), data2, 32'h0);
        end

        // Basic write/read.
        write(5, 32'hDEADBEEF);
        write(31, 32'h12345678);
        read(5, 31);
        check("basic_d1_r5", data1, 32'hDEADBEEF);
        check("basic_d2_r31", data2, 32'h12345678);
        read(31, 5);
        check("swap_d1_r31", data1, 32'h12345678);
        check("swap_d2_r5", data2, 32'hDEADBEEF);
        read(6, 30);
        check("neighbour_d1_r6", data1, 32'h0);
        check("neighbour_d2_r30", data2, 32'h0);

        // Writes to register 0 are discarded.
        write(0, 32'hFFFFFFFF);
        read(0, 0);
        check("r0_write_d1", data1, 32'h0);
        check("r0_write_d2", data2, 32'h0);

        // Write enable low leaves the register untouched.
        write(7, 32'hA5A5A5A5);
        write_reg = 7;
        writedata = 32'h1;
        regwrite  = 1'b0;
        @(posedge clk);
        #1;
        read(7, 7);
        check("we_low_d1_r7", data1, 32'hA5A5A5A5);
        check("we_low_d2_r7", data2, 32'hA5A5A5A5);

        // Read during write: old value before the edge, new value after.
        write(3, 32'h11);
        read(3, 3);
        write_reg = 3;
        writedata = 32'h22;
        regwrite  = 1'b1;
        #1;
        check("rdw_before_d1", data1, 32'h11);
        check("rdw_before_d2", data2, 32'h11);
        @(posedge clk);
        #1;
        regwrite = 1'b0;
        check("rdw_after_d1", data1, 32'h22);
        check("rdw_after_d2", data2, 32'h22);

        // Reset overrides a simultaneous write.
        write(9, 32'h55);
        read(9, 5);
        check("pre_rst_r9", data1, 32'h55);
        check("pre_rst_r5", data2, 32'hDEADBEEF);
        reset     = 1'b1;
        regwrite  = 1'b1;
        write_reg = 9;
        writedata = 32'h77;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        regwrite = 1'b0;
        read(9, 31);
        check("rst_prio_r9", data1, 32'h0);
        check("rst_prio_r31", data2, 32'h0);
        read(7, 3);
        check("rst_clear_r7", data1, 32'h0);
        check("rst_clear_r3", data2, 32'h0);

        // Write after reset still works.
        write(12, 32'hCAFEF00D);
        read(12, 0);
        check("post_rst_r12", data1, 32'hCAFEF00D);
        check("post_rst_r0", data2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
